// File: rtl/turfio_dout_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : turfio_dout_multi_if
// Description : Word handshake between the readout mux and the lane serialiser.
// Revision    : 1.0 - initial release
// ============================================================================
interface turfio_dout_multi_if #(
  parameter int NLANES    = 1,
  parameter int WORD_BITS = 8
);
  logic [NLANES*WORD_BITS-1:0] dout_data;
  logic                        dout_data_valid;
  logic                        dout_data_last;
  logic                        dout_data_phase;

  modport master (
    output dout_data,
    output dout_data_valid,
    output dout_data_last,
    input  dout_data_phase
  );

  modport slave (
    input  dout_data,
    input  dout_data_valid,
    input  dout_data_last,
    output dout_data_phase
  );
endinterface
`default_nettype wire

// File: rtl/turfio_dout_multi.sv
`default_nettype none
// ============================================================================
// Module      : turfio_dout_multi
// Description : Multi-lane framed word serialiser feeding same-clock ODDRE1s,
//               2 bits per clock, with training, underrun count and bit slip.
// Revision    : 1.0 - initial release
// ============================================================================
module turfio_dout_multi #(
  parameter int                    NLANES      = 1,
  parameter int                    WORD_BITS   = 8,
  parameter logic [WORD_BITS-1:0]  TRAIN_VALUE = 8'h6A,
  parameter logic [WORD_BITS-1:0]  IDLE_VALUE  = 8'h00,
  parameter logic [NLANES-1:0]     INV_DOUT    = '0
) (
  input  wire logic              ifclk_i,
  input  wire logic              rst_i,
  input  wire logic              sync_i,
  input  wire logic              train_i,
  turfio_dout_multi_if.slave     dout,
  input  wire logic [NLANES-1:0] slip_i,
  output logic [15:0]            underrun_o,
  output logic                   misalign_o,
  output logic [NLANES-1:0]      ddr_d1_o,
  output logic [NLANES-1:0]      ddr_d2_o
);
  localparam int c_BEATS  = WORD_BITS / 2;
  localparam int c_CNT_W  = $clog2(c_BEATS);
  localparam int c_SLIP_W = $clog2(WORD_BITS);
  localparam int c_IDX_W  = $clog2(WORD_BITS + 3);
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(c_BEATS - 1);
  localparam logic [c_SLIP_W-1:0] c_SLIP_LAST = c_SLIP_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TRAIN = 2'd1, ST_STREAM = 2'd2} state_t;
  typedef enum logic [1:0] {LD_IDLE = 2'd0, LD_TRAIN = 2'd1, LD_DATA = 2'd2} load_t;

  logic               r_sync_buf;
  logic               r_train_q;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_misalign;
  logic [15:0]        r_underrun;
  state_t             r_state;
  state_t             w_state_nxt;
  load_t              w_load_sel;
  logic               w_underrun_inc;
  logic               w_load;

  assign w_load               = (r_cnt == '0);
  assign dout.dout_data_phase = w_load && (r_state != ST_TRAIN) && !r_train_q;
  assign underrun_o           = r_underrun;
  assign misalign_o           = r_misalign;

  // A sync landing off-phase restarts the word count; the partial word is dropped.
  always_ff @(posedge ifclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync_buf <= 1'b0;
      r_train_q  <= 1'b0;
      r_cnt      <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_sync_buf <= sync_i;
      r_train_q  <= train_i;
      if (r_sync_buf) begin
        r_cnt <= c_CNT_W'(1);
        if (r_cnt != '0) r_misalign <= 1'b1;
      end else if (r_cnt == c_CNT_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ifclk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_underrun <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_underrun_inc && (r_underrun != 16'hFFFF)) r_underrun <= r_underrun + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_load_sel     = LD_IDLE;
    w_underrun_inc = 1'b0;
    if (w_load) begin
      if (r_train_q) begin
        w_state_nxt = ST_TRAIN;
        w_load_sel  = LD_TRAIN;
      end else if (dout.dout_data_valid) begin
        w_state_nxt = dout.dout_data_last ? ST_IDLE : ST_STREAM;
        w_load_sel  = LD_DATA;
      end else begin
        w_state_nxt    = ST_IDLE;
        w_underrun_inc = (r_state == ST_STREAM);
      end
    end
  end

  for (genvar n = 0; n < NLANES; n++) begin : g_lane
    logic [WORD_BITS-1:0] r_sr;
    logic [WORD_BITS:0]   r_hist;
    logic [c_SLIP_W-1:0]  r_slip;
    logic                 r_d1;
    logic                 r_d2;
    logic [WORD_BITS-1:0] w_word;
    logic [WORD_BITS+2:0] w_cat;
    logic [c_IDX_W-1:0]   w_idx1;
    logic [c_IDX_W-1:0]   w_idx2;

    always_comb begin
      w_word = IDLE_VALUE;
      case (w_load_sel)
        LD_TRAIN: w_word = TRAIN_VALUE;
        LD_DATA:  w_word = dout.dout_data[n*WORD_BITS +: WORD_BITS];
        default:  w_word = IDLE_VALUE;
      endcase
    end

    // Newest raw pair on top of the past bits; index WORD_BITS+1 is the current even bit.
    assign w_cat  = {r_sr[1:0], r_hist};
    assign w_idx1 = c_IDX_W'(WORD_BITS + 1) - c_IDX_W'(r_slip);
    assign w_idx2 = c_IDX_W'(WORD_BITS + 2) - c_IDX_W'(r_slip);

    always_ff @(posedge ifclk_i or posedge rst_i) begin
      if (rst_i) begin
        r_sr   <= '0;
        r_hist <= '0;
        r_slip <= '0;
        r_d1   <= INV_DOUT[n];
        r_d2   <= INV_DOUT[n];
      end else begin
        r_sr   <= w_load ? w_word : (r_sr >> 2);
        r_hist <= w_cat[WORD_BITS+2:2];
        if (slip_i[n]) r_slip <= (r_slip == c_SLIP_LAST) ? '0 : r_slip + 1'b1;
        r_d1   <= w_cat[w_idx1] ^ INV_DOUT[n];
        r_d2   <= w_cat[w_idx2] ^ INV_DOUT[n];
      end
    end

    assign ddr_d1_o[n] = r_d1;
    assign ddr_d2_o[n] = r_d2;
  end
endmodule
`default_nettype wire

// File: tb/tb_turfio_dout_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_turfio_dout_multi
// Description : Scoreboard bench for the two-lane serialiser, lane 1 inverted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turfio_dout_multi;
  logic        clk = 1'b0;
  logic        rst_i, sync_i, train_i;
  logic [1:0]  slip_i;
  logic [15:0] underrun_o;
  logic        misalign_o;
  logic [1:0]  ddr_d1_o, ddr_d2_o;

  always #5 clk = ~clk;

  turfio_dout_multi_if #(.NLANES(2), .WORD_BITS(8)) bus ();

  turfio_dout_multi #(
    .NLANES(2), .WORD_BITS(8), .TRAIN_VALUE(8'h6A), .IDLE_VALUE(8'h00), .INV_DOUT(2'b10)
  ) dut (
    .ifclk_i(clk), .rst_i(rst_i), .sync_i(sync_i), .train_i(train_i), .dout(bus),
    .slip_i(slip_i), .underrun_o(underrun_o), .misalign_o(misalign_o),
    .ddr_d1_o(ddr_d1_o), .ddr_d2_o(ddr_d2_o)
  );

  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    bit         chk;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_state;        // 0 idle, 1 train, 2 stream
  bit          m_train_q;
  logic [15:0] m_underrun;
  int          m_slip[2];
  logic [7:0]  cur0, cur1;
  bit          has_cur;

  function automatic logic [7:0] rotl8(input logic [7:0] w, input int s);
    logic [15:0] t;
    t = {w, w} << s;
    return t[15:8];
  endfunction

  task automatic sample_pair(input int idx);
    cur0[2*idx]   = ddr_d1_o[0];
    cur0[2*idx+1] = ddr_d2_o[0];
    cur1[2*idx]   = ddr_d1_o[1];
    cur1[2*idx+1] = ddr_d2_o[1];
  endtask

  task automatic complete_word();
    exp_t e;
    if (has_cur && sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        n_tests++;
        if (cur0 !== e.w0) begin
          n_fail++;
          $display("FAIL lane0_word: got %h want %h", cur0, e.w0);
        end
        n_tests++;
        if (cur1 !== e.w1) begin
          n_fail++;
          $display("FAIL lane1_word: got %h want %h", cur1, e.w1);
        end
      end
    end
  endtask

  // Called at cnt==0, 1 time unit after a clock edge; runs exactly one word period.
  task automatic word_cycle(input bit v, input bit l, input bit t, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [1:0] slp, input bit chk,
                            input bit sync_end);
    bit         exp_ph;
    logic [7:0] w0, w1;
    exp_t       e;
    exp_ph = (m_state != 1) && !m_train_q;
    n_tests++;
    if (bus.dout_data_phase !== exp_ph) begin
      n_fail++;
      $display("FAIL phase: got %b want %b", bus.dout_data_phase, exp_ph);
    end
    if (m_train_q) begin
      w0 = 8'h6A; w1 = 8'h6A; m_state = 1;
    end else if (v) begin
      w0 = d0; w1 = d1; m_state = l ? 0 : 2;
    end else begin
      w0 = 8'h00; w1 = 8'h00;
      if (m_state == 2 && m_underrun != 16'hFFFF) m_underrun = m_underrun + 16'd1;
      m_state = 0;
    end
    m_train_q = t;
    for (int n = 0; n < 2; n++) if (slp[n]) m_slip[n] = (m_slip[n] + 1) % 8;
    e.w0  = rotl8(w0, m_slip[0]);
    e.w1  = rotl8(w1, m_slip[1]) ^ 8'hFF;
    e.chk = chk;
    sb.push_back(e);

    bus.dout_data       = {d1, d0};
    bus.dout_data_valid = v;
    bus.dout_data_last  = l;
    train_i             = t;
    slip_i              = slp;
    @(posedge clk); #1;
    slip_i = 2'b00;
    sample_pair(3);
    complete_word();
    n_tests++;
    if (underrun_o !== m_underrun) begin
      n_fail++;
      $display("FAIL underrun: got %h want %h", underrun_o, m_underrun);
    end
    for (int k = 1; k < 4; k++) begin
      if (k == 3) sync_i = sync_end;
      @(posedge clk); #1;
      sync_i = 1'b0;
      sample_pair(k - 1);
    end
    has_cur = 1'b1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; sync_i = 1'b0; train_i = 1'b0; slip_i = 2'b00;
    bus.dout_data = '0; bus.dout_data_valid = 1'b0; bus.dout_data_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ddr_d1_o !== 2'b10 || ddr_d2_o !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_ddr: got d1=%b d2=%b want d1=10 d2=10", ddr_d1_o, ddr_d2_o);
    end
    n_tests++;
    if (underrun_o !== 16'h0 || misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got underrun=%h misalign=%b want 0 0", underrun_o, misalign_o);
    end
    n_tests++;
    if (bus.dout_data_phase !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_phase: got %b want 1", bus.dout_data_phase);
    end
    rst_i      = 1'b0;
    m_state    = 0;
    m_train_q  = 1'b0;
    m_underrun = 16'h0;
    m_slip[0]  = 0;
    m_slip[1]  = 0;
    has_cur    = 1'b0;
    sb.delete();
  endtask

  task automatic test_train();
    word_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
    n_tests++;
    if (misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL aligned_sync: got misalign=%b want 0", misalign_o);
    end
    repeat (5) word_cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_slip();
    repeat (3) word_cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
    repeat (2) word_cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    repeat (5) word_cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0);
    repeat (2) word_cycle(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    repeat (2) word_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_stream();
    word_cycle(1'b1, 1'b0, 1'b0, 8'h11, 8'h51, 2'b00, 1'b1, 1'b0);
    word_cycle(1'b1, 1'b0, 1'b0, 8'h22, 8'h62, 2'b00, 1'b1, 1'b0);
    word_cycle(1'b1, 1'b1, 1'b0, 8'h33, 8'h73, 2'b00, 1'b1, 1'b0);
    repeat (2) word_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_underrun();
    word_cycle(1'b1, 1'b0, 1'b0, 8'hA5, 8'h5A, 2'b00, 1'b1, 1'b0);
    word_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    n_tests++;
    if (underrun_o !== 16'h0001) begin
      n_fail++;
      $display("FAIL underrun_first: got %h want 0001", underrun_o);
    end
    force dut.r_underrun = 16'hFFFD;
    #1;
    release dut.r_underrun;
    m_underrun = 16'hFFFD;
    repeat (4) begin
      word_cycle(1'b1, 1'b0, 1'b0, 8'hC7, 8'h7C, 2'b00, 1'b1, 1'b0);
      word_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    end
    n_tests++;
    if (underrun_o !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL underrun_sat: got %h want FFFF", underrun_o);
    end
  endtask

  task automatic test_misalign();
    @(posedge clk); #1;
    @(posedge clk); #1;
    sync_i = 1'b1;
    @(posedge clk); #1;
    sync_i = 1'b0;
    n_tests++;
    if (bus.dout_data_phase !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_phase0: got %b want 0", bus.dout_data_phase);
    end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (bus.dout_data_phase !== (k == 4)) begin
        n_fail++;
        $display("FAIL misalign_phase%0d: got %b want %b", k, bus.dout_data_phase, (k == 4));
      end
      if (k == 1) begin
        n_tests++;
        if (misalign_o !== 1'b1) begin
          n_fail++;
          $display("FAIL misalign_set: got %b want 1", misalign_o);
        end
      end
    end
    sb.delete();
    has_cur = 1'b0;
    word_cycle(1'b1, 1'b1, 1'b0, 8'h3C, 8'hC3, 2'b00, 1'b1, 1'b0);
    repeat (2) word_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
    n_tests++;
    if (misalign_o !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_sticky: got %b want 1", misalign_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.dout_data       = {8'h0F, 8'hF0};
    bus.dout_data_valid = 1'b1;
    bus.dout_data_last  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.dout_data_valid = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (ddr_d1_o !== 2'b10 || ddr_d2_o !== 2'b10) begin
      n_fail++;
      $display("FAIL async_reset_ddr: got d1=%b d2=%b want d1=10 d2=10", ddr_d1_o, ddr_d2_o);
    end
    n_tests++;
    if (underrun_o !== 16'h0 || misalign_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_status: got underrun=%h misalign=%b want 0 0", underrun_o, misalign_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_train();
    test_slip();
    test_stream();
    test_underrun();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
